// File: rtl/joystick_dir_decoder.sv
// joystick_dir_decoder
// Turns raw 10-bit joystick X/Y samples into debounced one-shot direction
// events. A sample is classified as centred, in the hysteresis band, or
// off-centre. A direction must be seen on STABLE_CNT consecutive valid
// samples before it fires. After an event, the stick must return to centre
// before another event can fire.
module joystick_dir_decoder #(
   parameter int DATA_W     = 10,
   parameter int CENTER     = 512,
   parameter int DEAD       = 100,
   parameter int HYST       = 20,
   parameter int STABLE_CNT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] x_pos,
   input  logic [DATA_W-1:0] y_pos,
   output logic              event_valid,
   output logic [1:0]        event_dir,
   output logic              held,
   output logic [7:0]        event_count
);

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   localparam logic [DATA_W-1:0] OFF_THR = DATA_W'(DEAD);
   localparam logic [DATA_W-1:0] CTR_THR = DATA_W'(DEAD - HYST);
   localparam logic [3:0]        CNT_TGT = 4'(STABLE_CNT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_HELD = 2'd2
   } state_t;

   // Magnitude of a signed offset. The result is one bit narrower than the
   // input. The most negative offset (sample 0) maps to 512. That value still
   // fits in DATA_W bits because it is unsigned.
   function automatic logic [DATA_W-1:0] f_abs(input logic signed [DATA_W:0] v);
      logic signed [DATA_W:0] neg;
      neg = -v;
      return v[DATA_W] ? neg[DATA_W-1:0] : v[DATA_W-1:0];
   endfunction

   logic signed [DATA_W:0] w_dx;
   logic signed [DATA_W:0] w_dy;
   logic [DATA_W-1:0]      w_ax;
   logic [DATA_W-1:0]      w_ay;
   logic [DATA_W-1:0]      w_m;
   logic                   w_x_dom;
   logic                   w_off;
   logic                   w_ctr;
   logic [1:0]             w_dir;

   state_t      r_state;
   logic [1:0]  r_cand;
   logic [3:0]  r_cnt;
   logic        r_event_valid;
   logic [1:0]  r_event_dir;
   logic        r_held;
   logic [7:0]  r_event_count;

   assign w_dx = signed'({1'b0, x_pos}) - signed'((DATA_W + 1)'(CENTER));
   assign w_dy = signed'({1'b0, y_pos}) - signed'((DATA_W + 1)'(CENTER));
   assign w_ax = f_abs(w_dx);
   assign w_ay = f_abs(w_dy);

   // X wins ties, so the dominant-axis test uses >=.
   assign w_x_dom = (w_ax >= w_ay);
   assign w_m     = w_x_dom ? w_ax : w_ay;
   assign w_off   = (w_m > OFF_THR);
   assign w_ctr   = (w_m <= CTR_THR);

   // Classify the direction of the current sample. The result is only
   // meaningful when the sample is off-centre. In that case the dominant
   // offset is nonzero, so a zero offset cannot occur on the dominant axis.
   always_comb begin
      w_dir = DIR_UP;
      if (w_x_dom) begin
         w_dir = w_dx[DATA_W] ? DIR_LEFT : DIR_RIGHT;
      end else begin
         w_dir = w_dy[DATA_W] ? DIR_DOWN : DIR_UP;
      end
   end

   // Debounce FSM. All outputs are registered.
   // The event_valid pulse is cleared on every edge, whether or not a sample
   // arrives. All other state changes only on valid samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_cand        <= 2'b00;
         r_cnt         <= 4'd0;
         r_event_valid <= 1'b0;
         r_event_dir   <= 2'b00;
         r_held        <= 1'b0;
         r_event_count <= 8'd0;
      end else begin
         r_event_valid <= 1'b0;
         if (sample_valid) begin
            case (r_state)
               S_IDLE: begin
                  if (w_off) begin
                     r_cand  <= w_dir;
                     r_cnt   <= 4'd1;
                     r_state <= S_ARM;
                  end
               end
               S_ARM: begin
                  if (w_off) begin
                     if (w_dir == r_cand) begin
                        if (r_cnt + 4'd1 == CNT_TGT) begin
                           r_cnt         <= 4'd0;
                           r_state       <= S_HELD;
                           r_event_valid <= 1'b1;
                           r_event_dir   <= r_cand;
                           r_held        <= 1'b1;
                           r_event_count <= r_event_count + 8'd1;
                        end else begin
                           r_cnt <= r_cnt + 4'd1;
                        end
                     end else begin
                        r_cand <= w_dir;
                        r_cnt  <= 4'd1;
                     end
                  end else if (w_ctr) begin
                     r_cnt   <= 4'd0;
                     r_state <= S_IDLE;
                  end
               end
               S_HELD: begin
                  if (w_ctr) begin
                     r_held  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_cnt   <= 4'd0;
               end
            endcase
         end
      end
   end

   assign event_valid = r_event_valid;
   assign event_dir   = r_event_dir;
   assign held        = r_held;
   assign event_count = r_event_count;

endmodule

// File: tb/tb_joystick_dir_decoder.sv
// Directed bench for joystick_dir_decoder.
// Each step pushes its expected outputs to a scoreboard queue. The entry is
// popped and compared after the edge that consumes the step.
module tb_joystick_dir_decoder;

   logic       clk;
   logic       rst_n;
   logic       sample_valid;
   logic [9:0] x_pos;
   logic [9:0] y_pos;
   logic       event_valid;
   logic [1:0] event_dir;
   logic       held;
   logic [7:0] event_count;

   typedef struct {
      logic       ev;
      logic [1:0] dir;
      logic       hld;
      logic [7:0] cnt;
      string      tag;
   } exp_t;

   exp_t sb[$];

   int         n_checks = 0;
   int         n_err    = 0;
   logic [7:0] exp_cnt  = 8'd0;
   logic       cur_held = 1'b0;

   joystick_dir_decoder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .x_pos        (x_pos),
      .y_pos        (y_pos),
      .event_valid  (event_valid),
      .event_dir    (event_dir),
      .held         (held),
      .event_count  (event_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_front();
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({e.tag, ".valid"}, 32'(event_valid), 32'(e.ev));
         if (e.ev) chk({e.tag, ".dir"}, 32'(event_dir), 32'(e.dir));
         chk({e.tag, ".held"}, 32'(held), 32'(e.hld));
         chk({e.tag, ".count"}, 32'(event_count), 32'(e.cnt));
      end
   endtask

   // One valid sample; ev/dir/hld describe the outputs after its edge.
   task automatic step(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic ev, input logic [1:0] dir, input logic hld);
      exp_t e;
      if (ev) exp_cnt = exp_cnt + 8'd1;
      cur_held = hld;
      e.ev = ev; e.dir = dir; e.hld = hld; e.cnt = exp_cnt; e.tag = tag;
      sb.push_back(e);
      @(negedge clk);
      x_pos = x;
      y_pos = y;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      compare_front();
   endtask

   // Idle cycles with junk on the data inputs; no pulse, state unchanged.
   task automatic gap(input string tag, input int n);
      exp_t e;
      e.ev = 1'b0; e.dir = 2'b00; e.hld = cur_held; e.cnt = exp_cnt; e.tag = tag;
      sb.push_back(e);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         x_pos = 10'd0;
         y_pos = 10'd1023;
         sample_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      compare_front();
   endtask

   task automatic fire4(input string tag, input logic [9:0] x, input logic [9:0] y,
                        input logic [1:0] dir);
      step(tag, x, y, 1'b0, 2'b00, 1'b0);
      step(tag, x, y, 1'b0, 2'b00, 1'b0);
      step(tag, x, y, 1'b0, 2'b00, 1'b0);
      step(tag, x, y, 1'b1, dir, 1'b1);
   endtask

   task automatic release_ctr(input string tag);
      step(tag, 10'd512, 10'd512, 1'b0, 2'b00, 1'b0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_cnt  = 8'd0;
      cur_held = 1'b0;
      chk({tag, ".valid"}, 32'(event_valid), 32'd0);
      chk({tag, ".dir"},   32'(event_dir),   32'd0);
      chk({tag, ".held"},  32'(held),        32'd0);
      chk({tag, ".count"}, 32'(event_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      sample_valid = 1'b0;
      x_pos = 10'd512;
      y_pos = 10'd512;
      repeat (2) @(posedge clk);
      do_reset("reset_init");

      // Reset in the middle of arming restarts the count.
      step("midarm_pre", 10'd700, 10'd512, 1'b0, 2'b00, 1'b0);
      step("midarm_pre", 10'd700, 10'd512, 1'b0, 2'b00, 1'b0);
      do_reset("midarm_rst");
      step("midarm_post", 10'd700, 10'd512, 1'b0, 2'b00, 1'b0);
      step("midarm_post", 10'd700, 10'd512, 1'b0, 2'b00, 1'b0);
      step("midarm_post", 10'd700, 10'd512, 1'b0, 2'b00, 1'b0);
      release_ctr("midarm_ctr");

      // Basic fire with two idle cycles between samples.
      step("basic1", 10'd700, 10'd512, 1'b0, 2'b00, 1'b0);
      gap("basic_gap1", 2);
      step("basic2", 10'd700, 10'd512, 1'b0, 2'b00, 1'b0);
      gap("basic_gap2", 2);
      step("basic3", 10'd700, 10'd512, 1'b0, 2'b00, 1'b0);
      gap("basic_gap3", 2);
      step("basic4", 10'd700, 10'd512, 1'b1, 2'b11, 1'b1);
      gap("basic_pulse_drop", 1);
      release_ctr("basic_rel");

      // Hysteresis: dx=100 is band, not off.
      for (int i = 0; i < 4; i++) step("hyst_dead_edge", 10'd612, 10'd512, 1'b0, 2'b00, 1'b0);
      fire4("hyst_fire", 10'd700, 10'd512, 2'b11);
      step("hyst_band", 10'd600, 10'd512, 1'b0, 2'b00, 1'b1);
      step("hyst_ctr", 10'd592, 10'd512, 1'b0, 2'b00, 1'b0);
      fire4("hyst_up", 10'd512, 10'd900, 2'b00);
      release_ctr("hyst_rel");

      // Ties go to X; extremes.
      fire4("tie_right", 10'd700, 10'd700, 2'b11);
      release_ctr("tie_rel1");
      fire4("tie_left", 10'd300, 10'd724, 2'b10);
      release_ctr("tie_rel2");
      fire4("ext_x0", 10'd0, 10'd512, 2'b10);
      release_ctr("ext_rel1");
      fire4("ext_y1023", 10'd512, 10'd1023, 2'b00);
      release_ctr("ext_rel2");
      fire4("ext_down", 10'd512, 10'd100, 2'b01);
      release_ctr("ext_rel3");

      // Direction change while arming restarts the count on the new direction.
      for (int i = 0; i < 3; i++) step("chg_right", 10'd700, 10'd512, 1'b0, 2'b00, 1'b0);
      fire4("chg_up", 10'd512, 10'd800, 2'b00);
      release_ctr("chg_rel");

      // Lockout while held.
      fire4("lock_fire", 10'd700, 10'd512, 2'b11);
      for (int i = 0; i < 10; i++) step("lock_hold", 10'd100, 10'd512, 1'b0, 2'b00, 1'b1);
      release_ctr("lock_rel");

      // Counter wrap: 256 events from zero bring the count back to zero.
      do_reset("wrap_rst");
      for (int i = 0; i < 256; i++) begin
         fire4("wrap_fire", 10'd700, 10'd512, 2'b11);
         release_ctr("wrap_rel");
      end
      chk("wrap_final_count", 32'(event_count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/joystick_dir_decoder.md
# joystick_dir_decoder

Converts raw 10-bit joystick X/Y samples from the SPI joystick front end into debounced, one-shot direction events (UP/DOWN/LEFT/RIGHT) for the game-logic layer. It applies a dead zone with hysteresis and requires N consecutive agreeing samples before firing. After firing it requires a return to centre before the next event, so one physical flick produces exactly one event.

## Interface
- CENTER, 512: 10-bit rest position for both axes.
- DEAD, 100: a sample is off-centre when |delta| > DEAD.
- HYST, 20: a sample is centred when |delta| <= DEAD-HYST. Constraint: HYST < DEAD.
- STABLE_CNT, 4: consecutive agreeing valid samples needed to fire. Legal range 2..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sample_valid  in  1  x_pos/y_pos hold a new sample this cycle
- x_pos  in  10  unsigned X sample
- y_pos  in  10  unsigned Y sample
- event_valid  out  1  one-cycle pulse: a direction event fired
- event_dir  out  2  00 UP, 01 DOWN, 10 LEFT, 11 RIGHT; valid while event_valid=1, holds its last value otherwise
- held  out  1  high from the event pulse until release to centre
- event_count  out  8  number of events fired, wraps modulo 256

## Operation
- Cycles with sample_valid=0 are ignored entirely: no state, counter or classification change.
- Arithmetic:
  - dx = {1'b0,x_pos} - CENTER, computed as 11-bit signed; dy likewise.
  - |dx| and |dy| are 10-bit unsigned, max 512 (at x=0).
  - m = max(|dx|,|dy|).
- Classification of each valid sample:
  - OFF when m > DEAD.
  - CTR when m <= DEAD-HYST.
  - BAND otherwise.
- Direction of an OFF sample:
  - Dominant axis is the one with the larger magnitude; when |dx| == |dy|, X wins.
  - X axis: dx>0 gives RIGHT, dx<0 gives LEFT.
  - Y axis: dy>0 gives UP, dy<0 gives DOWN.
- FSM with states IDLE, ARM and HELD; internal registers cand[1:0] and cnt[3:0].
  - IDLE:
    - OFF: cand=dir, cnt=1, go to ARM.
    - CTR or BAND: stay in IDLE.
  - ARM:
    - OFF with dir==cand: cnt+1. If cnt+1==STABLE_CNT, fire and go to HELD, clearing cnt.
    - OFF with dir!=cand: cand=dir, cnt=1, stay in ARM.
    - BAND: cnt held, stay in ARM.
    - CTR: cnt=0, go to IDLE.
  - HELD:
    - CTR: held=0, go to IDLE.
    - OFF (any direction) or BAND: stay in HELD. No new event is fired.
- Fire action, all in the same edge:
  - event_valid=1, event_dir=cand, held=1.
  - event_count increments; 255 wraps to 0.
- Reset (rst_n low, at any time including mid-ARM or HELD):
  - state=IDLE, cand=00, cnt=0.
  - event_valid=0, event_dir=00, held=0, event_count=0.
  - Reset is asserted asynchronously. Release is used synchronously: the first sample is accepted on the first edge after rst_n rises.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Latency: the edge that samples the STABLE_CNT-th agreeing valid sample drives event_valid=1 for exactly the following cycle. event_valid drops at the next edge regardless of input.
- held rises at the same edge as event_valid. It falls at the edge that samples the first CTR sample in HELD.
- Back-to-back valid samples every cycle are supported. Gaps of any length between valid samples do not disturb the count.
- Minimum spacing between two events is STABLE_CNT+1 valid samples: 1 CTR sample plus STABLE_CNT OFF samples.

## Test plan
- Reset mid-ARM: 2 samples x=700,y=512, then rst_n=0 for 1 cycle, then 3 more x=700 samples -> no event (count restarts from 0); event_count=0, held=0.
- Basic fire: 4 valid samples x=700,y=512, one every 3 cycles -> single event_valid pulse after the 4th, event_dir=11, held=1, event_count=1.
- Hysteresis:
  - x=612 (dx=100) x4 -> no event.
  - Then fire RIGHT, then x=600 (dx=88, BAND) -> held stays 1.
  - Then x=592 (dx=80, CTR) -> held=0.
  - Then 4 samples of x=512,y=900 -> event_dir=00.
- Ties and extremes:
  - x=700,y=700 x4 -> RIGHT.
  - x=300,y=724 x4 (|dx|=|dy|=212) -> LEFT.
  - x=0 -> LEFT. y=1023 -> UP.
- Direction change in ARM: 3 samples RIGHT, then 4 samples UP (y=800) -> one event with event_dir=00 on the 4th UP sample; no RIGHT event.
- Wrap and lockout:
  - 256 fire/release cycles -> event_count returns to 0.
  - While HELD, 10 samples of x=100 -> no extra event.
